// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one sequential signed
// multiplier between four requesters and reports each finished product.
module mult_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk94,
    input  logic                 rst_n94,
    input  logic [3:0]           req94,
    input  logic [4*WIDTH-1:0]   opa94,
    input  logic [4*WIDTH-1:0]   opb94,
    output logic [3:0]           gnt94,
    output logic [3:0]           done94,
    output logic [2*WIDTH-1:0]   result94,
    output logic                 busy94,
    output logic [15:0]          op_count94,
    output logic                 m_start94,
    output logic [WIDTH-1:0]     m_multiplier94,
    output logic [WIDTH-1:0]     m_multiplicand94,
    input  logic                 m_ready94,
    input  logic [2*WIDTH-1:0]   m_product94
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_LOW = 2'd2,
        WAIT_HI  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win_q, win_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [3:0]         done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;

    logic [WIDTH-1:0]   opa_arr [4];
    logic [WIDTH-1:0]   opb_arr [4];
    logic               found;
    logic [1:0]         pick;
    logic [1:0]         idx;

    for (genvar g = 0; g < 4; g++) begin : g_slice
        assign opa_arr[g] = opa94[g*WIDTH +: WIDTH];
        assign opb_arr[g] = opb94[g*WIDTH +: WIDTH];
    end

    // First active request at or after the pointer, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req94[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = 4'b0000;
        done_d   = 4'b0000;
        result_d = result_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        unique case (state_q)
            IDLE: begin
                if (m_ready94 && found) begin
                    gnt_d   = 4'b0001 << pick;
                    win_d   = pick;
                    ptr_d   = pick + 2'd1;
                    opa_d   = opa_arr[pick];
                    opb_d   = opb_arr[pick];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!m_ready94) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (m_ready94) begin
                    result_d = m_product94;
                    done_d   = 4'b0001 << win_q;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk94 or negedge rst_n94) begin
        if (!rst_n94) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            win_q    <= 2'd0;
            gnt_q    <= 4'b0000;
            done_q   <= 4'b0000;
            result_q <= '0;
            cnt_q    <= 16'd0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
        end
    end

    // Operands stay put after ISSUE: the multiplier's sign fix-up reads them late.
    assign m_multiplier94   = opa_q;
    assign m_multiplicand94 = opb_q;
    assign m_start94        = (state_q == ISSUE);
    assign busy94           = (state_q != IDLE);
    assign gnt94            = gnt_q;
    assign done94           = done_q;
    assign result94         = result_q;
    assign op_count94       = cnt_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a WIDTH-cycle behavioural multiplier
// and directed vectors checked against hand-computed products.
module tb_mult_arbiter;

    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [4*W-1:0]  opa;
    logic [4*W-1:0]  opb;
    logic [3:0]      gnt;
    logic [3:0]      done;
    logic [2*W-1:0]  result;
    logic            busy;
    logic [15:0]     op_count;
    logic            m_start;
    logic [W-1:0]    m_mul;
    logic [W-1:0]    m_mcd;
    logic            m_ready;
    logic [2*W-1:0]  m_prod;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_done = -1;
    int mcnt = 0;

    mult_arbiter #(.WIDTH(W)) dut (
        .clk94            (clk),
        .rst_n94          (rst_n),
        .req94            (req),
        .opa94            (opa),
        .opb94            (opb),
        .gnt94            (gnt),
        .done94           (done),
        .result94         (result),
        .busy94           (busy),
        .op_count94       (op_count),
        .m_start94        (m_start),
        .m_multiplier94   (m_mul),
        .m_multiplicand94 (m_mcd),
        .m_ready94        (m_ready),
        .m_product94      (m_prod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sequential multiplier: no reset, busy for W cycles after a start.
    always @(posedge clk) begin
        if (m_start) begin
            m_ready <= 1'b0;
            mcnt    <= W - 1;
        end else if (!m_ready) begin
            if (mcnt == 0) begin
                m_ready <= 1'b1;
                m_prod  <= $signed(m_mul) * $signed(m_mcd);
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        opa[i*W +: W] = a;
        opb[i*W +: W] = b;
    endtask

    task automatic wait_gnt(output int c);
        int n = 0;
        while (gnt == 4'b0000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (gnt == 4'b0000) check("gnt_timeout", 64'd0, 64'd1);
        c = cyc;
    endtask

    task automatic wait_done(output int c);
        int n = 0;
        while (done == 4'b0000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done == 4'b0000) check("done_timeout", 64'd0, 64'd1);
        c = cyc;
    endtask

    // One full transaction: grant, start, completion, latency, product.
    task automatic do_op(input string tag, input int w,
                         input logic [31:0] exp_res,
                         input logic [15:0] exp_cnt,
                         input logic [3:0] req_after);
        int g;
        int d;
        wait_gnt(g);
        check({tag, "_gnt"}, gnt, 64'(4'b0001 << w));
        check({tag, "_start"}, m_start, 1);
        check({tag, "_busy"}, busy, 1);
        if (last_done >= 0) check({tag, "_b2b"}, g, last_done + 1);
        req = req_after;
        @(negedge clk);
        check({tag, "_gnt_end"}, gnt, 0);
        check({tag, "_start_end"}, m_start, 0);
        wait_done(d);
        check({tag, "_done"}, done, 64'(4'b0001 << w));
        check({tag, "_lat"}, d - g, W + 2);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_cnt"}, op_count, exp_cnt);
        last_done = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_done = -1;
    endtask

    initial begin
        int g;
        int early;
        rst_n   = 1'b1;
        req     = 4'b0000;
        opa     = '0;
        opb     = '0;
        m_ready = 1'b1;
        m_prod  = '0;

        // Reset asserted mid-cycle, outputs checked before any edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_res", result, 0);
        check("rst_cnt", op_count, 0);
        check("rst_busy", busy, 0);
        check("rst_start", m_start, 0);
        check("rst_mul", {m_mul, m_mcd}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request: -3 * 5.
        set_op(0, 16'hFFFD, 16'h0005);
        req = 4'b0001;
        do_op("single", 0, 32'hFFFF_FFF1, 16'd1, 4'b0000);
        check("single_hold_a", m_mul, 16'hFFFD);
        check("single_hold_b", m_mcd, 16'h0005);
        @(negedge clk);
        check("single_done_end", done, 0);
        check("single_res_hold", result, 32'hFFFF_FFF1);
        check("single_no_regnt", gnt, 0);

        // All four requesting from reset.
        do_reset();
        set_op(0, 16'h0002, 16'h0003);
        set_op(1, 16'hFFFF, 16'hFFFF);
        set_op(2, 16'h0100, 16'hFF00);
        set_op(3, 16'h1234, 16'h0010);
        req = 4'b1111;
        do_op("all0", 0, 32'h0000_0006, 16'd1, 4'b1111);
        set_op(0, 16'h7FFF, 16'hFFFF);
        do_op("all1", 1, 32'h0000_0001, 16'd2, 4'b1111);
        do_op("all2", 2, 32'hFFFF_0000, 16'd3, 4'b1111);
        do_op("all3", 3, 32'h0001_2340, 16'd4, 4'b1111);
        do_op("all4", 0, 32'hFFFF_8001, 16'd5, 4'b0000);

        // Round-robin: 2 first, then 1010 gives 3 then 1.
        @(negedge clk);
        last_done = -1;
        set_op(2, 16'h0000, 16'h1234);
        set_op(3, 16'h0003, 16'hFFFE);
        set_op(1, 16'hFFF0, 16'hFFF0);
        req = 4'b0100;
        do_op("rr2", 2, 32'h0000_0000, 16'd6, 4'b1010);
        do_op("rr3", 3, 32'hFFFF_FFFA, 16'd7, 4'b1010);
        do_op("rr1", 1, 32'h0000_0100, 16'd8, 4'b0000);

        // Reset while waiting on a running multiplier.
        @(negedge clk);
        set_op(0, 16'h0005, 16'h0007);
        req = 4'b0001;
        wait_gnt(g);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_gnt", gnt, 0);
        check("mid_done", done, 0);
        check("mid_res", result, 0);
        check("mid_cnt", op_count, 0);
        check("mid_busy0", busy, 0);
        check("mid_mul", {m_mul, m_mcd}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_op(0, 16'h8000, 16'h8000);
        req = 4'b0001;
        early = 0;
        g = 0;
        while (!m_ready && g < 200) begin
            if (gnt != 4'b0000 || done != 4'b0000) early++;
            @(negedge clk);
            g++;
        end
        check("mid_no_early", early, 0);
        last_done = -1;
        do_op("minmin", 0, 32'h4000_0000, 16'd1, 4'b0000);

        // Counter saturation from a preloaded value.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        check("sat_preload", op_count, 16'hFFFE);
        last_done = -1;
        set_op(2, 16'h0001, 16'h0001);
        req = 4'b0100;
        do_op("sat1", 2, 32'h0000_0001, 16'hFFFF, 4'b0000);
        @(negedge clk);
        last_done = -1;
        set_op(3, 16'h7FFF, 16'h7FFF);
        req = 4'b1000;
        do_op("sat2", 3, 32'h3FFF_0001, 16'hFFFF, 4'b0000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width; product and result width is 2*WIDTH.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk94 in 1, rising-edge clock for all state; rst_n94 in 1, asynchronous active-low reset.
REQ-003 SHALL have port req94 in 4: per-requester level request.
REQ-004 SHALL have port opa94 in 4*WIDTH: multiplier operands; requester i uses bits [i*WIDTH +: WIDTH], two's complement.
REQ-005 SHALL have port opb94 in 4*WIDTH: multiplicand operands, same slicing.
REQ-006 SHALL have port gnt94 out 4: one-hot grant pulse, one cycle long.
REQ-007 SHALL have port done94 out 4: one-hot completion pulse, one cycle long.
REQ-008 SHALL have port result94 out 2*WIDTH: signed product of the last completed operation.
REQ-009 SHALL have port busy94 out 1: high when the FSM is not in IDLE.
REQ-010 SHALL have port op_count94 out 16: count of completed operations, saturating.
REQ-011 SHALL have port m_start94 out 1: start to the shared sequential multiplier.
REQ-012 SHALL have ports m_multiplier94 and m_multiplicand94, out, WIDTH each: operands to the multiplier.
REQ-013 SHALL have port m_ready94 in 1: multiplier idle (ready) flag.
REQ-014 SHALL have port m_product94 in 2*WIDTH: multiplier product, valid while m_ready94 is high after a completed operation.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT_LOW and WAIT_HI.
REQ-016 IDLE: at an edge where m_ready94=1 and req94!=0, SHALL select the winner by round-robin, latch the winner's opa/opb slices, register gnt94[winner]=1 for the next cycle, and go to ISSUE.
REQ-017 IDLE with m_ready94=0 SHALL grant nothing and stay in IDLE, whatever req94 is.
REQ-018 Round-robin: SHALL keep a 2-bit pointer ptr and search priority in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-019 Round-robin: after a grant to i, ptr SHALL become (i+1) mod 4.
REQ-020 ISSUE: m_start94 SHALL be 1 for exactly this one cycle; the FSM then SHALL go to WAIT_LOW.
REQ-021 WAIT_LOW: SHALL stay until m_ready94 is sampled 0, then go to WAIT_HI.
REQ-022 WAIT_HI: at the edge where m_ready94 is sampled 1, SHALL register result94<=m_product94, pulse done94[winner] for the next cycle, increment op_count94, and go to IDLE.
REQ-023 m_multiplier94 and m_multiplicand94 SHALL be driven only from the latched registers.
REQ-024 The latched operands SHALL stay constant from ISSUE until the next grant, because the multiplier's final sign correction reads its operand inputs.
REQ-025 Latency: with a WIDTH-cycle multiplier, the done94 pulse SHALL come WIDTH+2 clock edges after the gnt94 pulse.
REQ-026 Back-to-back: the next grant SHALL be possible at the edge after the done edge, giving one operation per WIDTH+3 cycles.
REQ-027 Requester protocol: req94[i] and its operand slices SHALL be held until gnt94[i].
REQ-028 req94 is sampled only in IDLE; a req94[i] still high when the FSM returns to IDLE SHALL count as a new request.
REQ-029 result94 SHALL hold its value between done pulses.
REQ-030 op_count94 SHALL stop at 0xFFFF and not wrap.
REQ-031 Outside its pulse cycle, each of gnt94, done94 and m_start94 SHALL be 0.

Reset
REQ-032 On rst_n94=0, asynchronously: the FSM SHALL go to IDLE, and ptr, gnt94, done94, result94, op_count94, m_start94 and the latched operands SHALL all clear to 0; busy94 SHALL be 0.
REQ-033 The multiplier has no reset. Reset during an operation SHALL abandon that operation with no done94.
REQ-034 After reset, no grant SHALL occur until m_ready94 is sampled 1.

Verification
REQ-035 Reset scenario: assert rst_n94 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-036 Single request: req94=0001, opa=0xFFFD, opb=0x0005 -> gnt94=0001 for 1 cycle, then m_start94 for 1 cycle; done94=0001 18 edges after gnt; result94=0xFFFFFFF1; op_count94=1.
REQ-037 All requesting from reset: req94=1111 held -> grant order 0,1,2,3,0; each done precedes the next gnt; each result correct for its distinct operands.
REQ-038 Round-robin order: grant to 2 while req94=1010 -> next grant 3, then 1.
REQ-039 Reset while in WAIT_HI, with m_ready94 held low by the still-running multiplier -> no done94; req94=0001 is not granted until m_ready94=1; the subsequent operation 0x8000*0x8000 -> result94=0x40000000.
REQ-040 Boundary values: 0x0000*0x1234 -> 0x00000000; 0x7FFF*0xFFFF -> 0xFFFF8001; with op_count94 preloaded by 65535 operations, one more operation -> op_count94 stays 0xFFFF.
